conv_row_engine: RTL

Streaming 1-D convolution engine: loads up to 2^N_WIDTH−1 filters once, then convolves each tagged IFMap row against every filter at a programmable stride, optionally adds an incoming partial sum, and emits saturated results through a small output FIFO. It sits in the CAD6 conv datapath between the IFMap/filter feeders and the psum writeback, as the multi-filter, fully handshaked successor of the single-mode Conv block.

---
 rtl/conv_pkg.sv | 13 +
 rtl/psum_fifo.sv | 43 ++++
 rtl/conv_row_engine.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, if_data tag positions and result saturation for the conv row engine
package conv_pkg;
  localparam int W = 16;
  localparam int FW = 4;
  localparam int ACC_WIDTH = 2 * W + FW;
  localparam int START_TAG = W + 1;
  localparam int END_TAG = W;
  typedef enum logic [2:0] {IDLE, LOAD_FILT, LOAD_ROW, MAC, PSUM, PUSH, ROW_END} state_t;
  function automatic logic [W-1:0] saturate(input logic [ACC_WIDTH-1:0] a);
    return (&a[ACC_WIDTH-1:W-1] || ~|a[ACC_WIDTH-1:W-1]) ? a[W-1:0]
                                                          : {a[ACC_WIDTH-1], {(W-1){~a[ACC_WIDTH-1]}}};
  endfunction
endpackage

// File: rtl/psum_fifo.sv
// psum_fifo: small synchronous result FIFO with count-based full/empty and a flush
module psum_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign wr = wr_en && !full;
  assign rd = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk)
    if (wr && !flush) mem[wp] <= wr_data;
endmodule

// File: rtl/conv_row_engine.sv
// conv_row_engine: multi-filter strided 1-D row convolution with optional psum add and saturated FIFO output
module conv_row_engine
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IF_DEPTH = 8,
  parameter int IF_ADDR_WIDTH = 3,
  parameter int FILTER_DEPTH = 16,
  parameter int FILTER_ADDR_WIDTH = 4,
  parameter int N_WIDTH = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [N_WIDTH-1:0]           cfg_n,
  input  logic [FILTER_ADDR_WIDTH-1:0] cfg_filter_size,
  input  logic [IF_ADDR_WIDTH-1:0]     cfg_stride,
  input  logic                         cfg_acc_psum,
  input  logic                         flt_valid,
  output logic                         flt_ready,
  input  logic [DATA_WIDTH-1:0]        flt_data,
  input  logic                         if_valid,
  output logic                         if_ready,
  input  logic [DATA_WIDTH+1:0]        if_data,
  input  logic                         psum_in_valid,
  output logic                         psum_in_ready,
  input  logic [DATA_WIDTH-1:0]        psum_in_data,
  output logic                         psum_out_valid,
  input  logic                         psum_out_ready,
  output logic [DATA_WIDTH-1:0]        psum_out_data,
  output logic                         row_done,
  output logic                         busy,
  output logic                         ovf
);
  localparam int LW = IF_ADDR_WIDTH + 1;
  localparam int CW = N_WIDTH + FILTER_ADDR_WIDTH;
  localparam int XW = LW + FILTER_ADDR_WIDTH;
  localparam int ACC_W = 2 * DATA_WIDTH + FILTER_ADDR_WIDTH;
  state_t state, state_nxt;
  logic [N_WIDTH-1:0] n_r, f;
  logic [FILTER_ADDR_WIDTH-1:0] fs_r, k;
  logic [IF_ADDR_WIDTH-1:0] stride_r;
  logic acc_psum_r, in_row, st, en, row_end, last_tap, last_flt, win_ok, fifo_full, fifo_empty;
  logic [CW-1:0] flt_cnt, flt_total, fa;
  logic [LW-1:0] len, len_nxt, pos, pos_nxt, ia;
  logic signed [ACC_W-1:0] acc, prod, psum_ext;
  logic signed [DATA_WIDTH-1:0] flt_mem [FILTER_DEPTH];
  logic signed [DATA_WIDTH-1:0] if_mem [IF_DEPTH];
  assign flt_ready = state == LOAD_FILT;
  assign if_ready = state == LOAD_ROW;
  assign psum_in_ready = state == PSUM;
  assign row_done = state == ROW_END;
  assign busy = state != IDLE;
  assign psum_out_valid = !fifo_empty;
  assign flt_total = CW'(n_r) * CW'(fs_r);
  assign st = if_data[START_TAG];
  assign en = if_data[END_TAG];
  // a row only ends on an end tag once a start tag has opened it
  assign row_end = en && (st || in_row);
  assign len_nxt = st ? LW'(1) : (len < LW'(IF_DEPTH) ? len + LW'(1) : len);
  assign last_tap = k == fs_r - FILTER_ADDR_WIDTH'(1);
  assign last_flt = f == n_r - N_WIDTH'(1);
  assign pos_nxt = pos + LW'(stride_r);
  assign win_ok = XW'(pos_nxt) + XW'(fs_r) <= XW'(len);
  assign ia = pos + LW'(k);
  assign fa = CW'(f) * CW'(fs_r) + CW'(k);
  assign prod = ACC_W'(if_mem[ia[IF_ADDR_WIDTH-1:0]]) * ACC_W'(flt_mem[fa[FILTER_ADDR_WIDTH-1:0]]);
  assign psum_ext = ACC_W'($signed(psum_in_data));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_FILT: if (flt_valid && flt_cnt == flt_total - CW'(1)) state_nxt = LOAD_ROW;
      LOAD_ROW:  if (if_valid && row_end) state_nxt = XW'(len_nxt) >= XW'(fs_r) ? MAC : ROW_END;
      MAC:       if (last_tap) state_nxt = acc_psum_r ? PSUM : PUSH;
      PSUM:      if (psum_in_valid) state_nxt = PUSH;
      PUSH:      if (!fifo_full) state_nxt = (!last_flt || win_ok) ? MAC : ROW_END;
      ROW_END:   state_nxt = LOAD_ROW;
      default:   ;
    endcase
    if (start) state_nxt = (cfg_n != '0 && cfg_filter_size != '0) ? LOAD_FILT : IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_r <= '0;
      fs_r <= '0;
      stride_r <= '0;
      acc_psum_r <= 1'b0;
      flt_cnt <= '0;
      len <= '0;
      pos <= '0;
      in_row <= 1'b0;
      f <= '0;
      k <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else if (start) begin
      n_r <= cfg_n;
      fs_r <= cfg_filter_size;
      stride_r <= cfg_stride == '0 ? IF_ADDR_WIDTH'(1) : cfg_stride;
      acc_psum_r <= cfg_acc_psum;
      flt_cnt <= '0;
      len <= '0;
      pos <= '0;
      in_row <= 1'b0;
      f <= '0;
      k <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      case (state)
        LOAD_FILT: if (flt_valid) flt_cnt <= flt_cnt + CW'(1);
        LOAD_ROW: if (if_valid) begin
          if (st || in_row) len <= len_nxt;
          if (!st && in_row && len == LW'(IF_DEPTH)) ovf <= 1'b1;
          in_row <= (st || in_row) && !en;
          if (row_end) begin
            pos <= '0;
            f <= '0;
            k <= '0;
            acc <= '0;
          end
        end
        MAC: begin
          acc <= acc + prod;
          k <= last_tap ? '0 : k + FILTER_ADDR_WIDTH'(1);
        end
        PSUM: if (psum_in_valid) acc <= acc + psum_ext;
        PUSH: if (!fifo_full) begin
          acc <= '0;
          f <= last_flt ? '0 : f + N_WIDTH'(1);
          if (last_flt) pos <= pos_nxt;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (state == LOAD_FILT && flt_valid && !start && flt_cnt < CW'(FILTER_DEPTH))
      flt_mem[flt_cnt[FILTER_ADDR_WIDTH-1:0]] <= flt_data;
    if (state == LOAD_ROW && if_valid && !start && (st || (in_row && len < LW'(IF_DEPTH))))
      if_mem[st ? '0 : len[IF_ADDR_WIDTH-1:0]] <= if_data[DATA_WIDTH-1:0];
  end
  psum_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .flush(start),
    .wr_en(state == PUSH),
    .wr_data(saturate(acc)),
    .full(fifo_full),
    .rd_en(psum_out_ready),
    .rd_data(psum_out_data),
    .empty(fifo_empty)
  );
endmodule
